alu_exec_wb: RTL and testbench

- Consumer end of the issue-queue issue interface: two ALU lanes that take issued ops and read operands from the physical register file (PRF).
- Executes each op, writes the result back to the PRF, and drives the writeback broadcast (valid + phys_rd) into the issue queue for wakeup.
- Reports completion (rob_addr, bank_addr) to the ROB.
- Fixed two-cycle latency pipeline with no backpressure: every issued op is accepted.

---
 rtl/alu_exec_wb.sv | 207 ++++++++++++++++++++
 tb/tb_alu_exec_wb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_wb.sv
// alu_exec_wb: two-lane ALU execute/writeback block at the consumer end of the
// issue queue. Each lane is a fixed RR -> EX -> WB pipeline with no
// backpressure:
//   RR : PRF read addresses are driven straight from the issue fields.
//   EX : operands come back from the PRF and the ALU result is computed.
//   WB : the PRF write, the wakeup broadcast and the ROB completion are all
//        driven from one register set, so they are aligned with each other.
// Build option: define ALU_EXEC_WB_BYPASS_EN to forward the WB-stage results
// into the EX operands. This covers a read that lands in the same cycle as the
// PRF write to the same tag. Without the macro, operands come only from the PRF.

package common;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRL  = 4'd3,
        ALU_SRA  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_AND  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_XOR  = 4'd9
    } alu_cmd_t;

    typedef enum logic [1:0] {
        OP_REG = 2'd0,
        OP_IMM = 2'd1
    } op_type_t;
endpackage

module alu_exec_wb #(
    parameter int DISPATCH_WIDTH       = 2,
    parameter int DISPATCH_ADDR_WIDTH  = 1,
    parameter int PHYS_REGS_ADDR_WIDTH = 6,
    parameter int ROB_ADDR_WIDTH       = 4,
    parameter int DATA_WIDTH           = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,

    input  logic [DISPATCH_WIDTH-1:0]       issue_valid,
    input  common::alu_cmd_t                issue_alu_cmd   [DISPATCH_WIDTH],
    input  logic [PHYS_REGS_ADDR_WIDTH-1:0] issue_op1       [DISPATCH_WIDTH],
    input  common::op_type_t                issue_op2_type  [DISPATCH_WIDTH],
    input  logic [31:0]                     issue_op2       [DISPATCH_WIDTH],
    input  logic [PHYS_REGS_ADDR_WIDTH-1:0] issue_phys_rd   [DISPATCH_WIDTH],
    input  logic [DISPATCH_ADDR_WIDTH-1:0]  issue_bank_addr [DISPATCH_WIDTH],
    input  logic [ROB_ADDR_WIDTH-1:0]       issue_rob_addr  [DISPATCH_WIDTH],

    output logic [PHYS_REGS_ADDR_WIDTH-1:0] prf_raddr1      [DISPATCH_WIDTH],
    output logic [PHYS_REGS_ADDR_WIDTH-1:0] prf_raddr2      [DISPATCH_WIDTH],
    input  logic [DATA_WIDTH-1:0]           prf_rdata1      [DISPATCH_WIDTH],
    input  logic [DATA_WIDTH-1:0]           prf_rdata2      [DISPATCH_WIDTH],

    output logic [DISPATCH_WIDTH-1:0]       prf_we,
    output logic [PHYS_REGS_ADDR_WIDTH-1:0] prf_waddr       [DISPATCH_WIDTH],
    output logic [DATA_WIDTH-1:0]           prf_wdata       [DISPATCH_WIDTH],

    output logic [DISPATCH_WIDTH-1:0]       wb_valid,
    output logic [PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd      [DISPATCH_WIDTH],

    output logic [DISPATCH_WIDTH-1:0]       cmpl_valid,
    output logic [ROB_ADDR_WIDTH-1:0]       cmpl_rob_addr   [DISPATCH_WIDTH],
    output logic [DISPATCH_ADDR_WIDTH-1:0]  cmpl_bank_addr  [DISPATCH_WIDTH]
);
    import common::*;

    // EX-stage registers
    logic [DISPATCH_WIDTH-1:0]       ex_valid;
    alu_cmd_t                        ex_cmd   [DISPATCH_WIDTH];
    op_type_t                        ex_type  [DISPATCH_WIDTH];
    logic [DATA_WIDTH-1:0]           ex_imm   [DISPATCH_WIDTH];
    logic [PHYS_REGS_ADDR_WIDTH-1:0] ex_rd    [DISPATCH_WIDTH];
    logic [DISPATCH_ADDR_WIDTH-1:0]  ex_bank  [DISPATCH_WIDTH];
    logic [ROB_ADDR_WIDTH-1:0]       ex_rob   [DISPATCH_WIDTH];
`ifdef ALU_EXEC_WB_BYPASS_EN
    logic [PHYS_REGS_ADDR_WIDTH-1:0] ex_tag1  [DISPATCH_WIDTH];
    logic [PHYS_REGS_ADDR_WIDTH-1:0] ex_tag2  [DISPATCH_WIDTH];
`endif

    // EX-stage combinational operands and result
    logic [DATA_WIDTH-1:0]           op_a     [DISPATCH_WIDTH];
    logic [DATA_WIDTH-1:0]           op_b     [DISPATCH_WIDTH];
    logic [DATA_WIDTH-1:0]           alu_res  [DISPATCH_WIDTH];

    // WB-stage registers
    logic [DISPATCH_WIDTH-1:0]       wb_vld_q;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] wb_rd_q   [DISPATCH_WIDTH];
    logic [DATA_WIDTH-1:0]           wb_data_q [DISPATCH_WIDTH];
    logic [DISPATCH_ADDR_WIDTH-1:0]  wb_bank_q [DISPATCH_WIDTH];
    logic [ROB_ADDR_WIDTH-1:0]       wb_rob_q  [DISPATCH_WIDTH];

    // RR: PRF read addresses follow the issue fields regardless of valid
    always_comb begin
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            prf_raddr1[l] = issue_op1[l];
            prf_raddr2[l] = issue_op2[l][PHYS_REGS_ADDR_WIDTH-1:0];
        end
    end

    // EX valid bits: reset and flush kill whatever is entering EX
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid <= '0;
        end else begin
            ex_valid <= issue_valid;
        end
    end

    // EX control/data capture; no reset needed since the valid bit qualifies it
    always_ff @(posedge clk) begin
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            ex_cmd[l]  <= issue_alu_cmd[l];
            ex_type[l] <= issue_op2_type[l];
            ex_imm[l]  <= issue_op2[l][DATA_WIDTH-1:0];
            ex_rd[l]   <= issue_phys_rd[l];
            ex_bank[l] <= issue_bank_addr[l];
            ex_rob[l]  <= issue_rob_addr[l];
`ifdef ALU_EXEC_WB_BYPASS_EN
            ex_tag1[l] <= issue_op1[l];
            ex_tag2[l] <= issue_op2[l][PHYS_REGS_ADDR_WIDTH-1:0];
`endif
        end
    end

    // EX operand select: PRF data or immediate, optionally forwarded from WB
    always_comb begin
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            op_a[l] = prf_rdata1[l];
            case (ex_type[l])
                OP_REG:  op_b[l] = prf_rdata2[l];
                OP_IMM:  op_b[l] = ex_imm[l];
                default: op_b[l] = '0;
            endcase
`ifdef ALU_EXEC_WB_BYPASS_EN
            // Ascending lane order lets lane 1 override lane 0 on a double match
            for (int s = 0; s < DISPATCH_WIDTH; s++) begin
                if (wb_vld_q[s] && (wb_rd_q[s] == ex_tag1[l])) begin
                    op_a[l] = wb_data_q[s];
                end
                if (wb_vld_q[s] && (ex_type[l] == OP_REG) && (wb_rd_q[s] == ex_tag2[l])) begin
                    op_b[l] = wb_data_q[s];
                end
            end
`endif
        end
    end

    // EX ALU; unknown commands yield 0 but the op still completes
    always_comb begin
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            alu_res[l] = '0;
            case (ex_cmd[l])
                ALU_ADD:  alu_res[l] = op_a[l] + op_b[l];
                ALU_SUB:  alu_res[l] = op_a[l] - op_b[l];
                ALU_SLL:  alu_res[l] = op_a[l] << op_b[l][4:0];
                ALU_SRL:  alu_res[l] = op_a[l] >> op_b[l][4:0];
                ALU_SRA:  alu_res[l] = $unsigned($signed(op_a[l]) >>> op_b[l][4:0]);
                ALU_SLT:  alu_res[l] = {{(DATA_WIDTH-1){1'b0}},
                                        ($signed(op_a[l]) < $signed(op_b[l]))};
                ALU_SLTU: alu_res[l] = {{(DATA_WIDTH-1){1'b0}}, (op_a[l] < op_b[l])};
                ALU_AND:  alu_res[l] = op_a[l] & op_b[l];
                ALU_OR:   alu_res[l] = op_a[l] | op_b[l];
                ALU_XOR:  alu_res[l] = op_a[l] ^ op_b[l];
                default:  alu_res[l] = '0;
            endcase
        end
    end

    // WB register: reset zeroes every output, flush only drops the valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_vld_q <= '0;
            for (int l = 0; l < DISPATCH_WIDTH; l++) begin
                wb_rd_q[l]   <= '0;
                wb_data_q[l] <= '0;
                wb_bank_q[l] <= '0;
                wb_rob_q[l]  <= '0;
            end
        end else begin
            wb_vld_q <= flush ? '0 : ex_valid;
            for (int l = 0; l < DISPATCH_WIDTH; l++) begin
                wb_rd_q[l]   <= ex_rd[l];
                wb_data_q[l] <= alu_res[l];
                wb_bank_q[l] <= ex_bank[l];
                wb_rob_q[l]  <= ex_rob[l];
            end
        end
    end

    // WB outputs: one register set feeds the PRF write, wakeup and completion
    always_comb begin
        prf_we     = wb_vld_q;
        wb_valid   = wb_vld_q;
        cmpl_valid = wb_vld_q;
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            prf_waddr[l]      = wb_rd_q[l];
            prf_wdata[l]      = wb_data_q[l];
            wb_phys_rd[l]     = wb_rd_q[l];
            cmpl_rob_addr[l]  = wb_rob_q[l];
            cmpl_bank_addr[l] = wb_bank_q[l];
        end
    end

endmodule

// File: tb/tb_alu_exec_wb.sv
// Bench for alu_exec_wb. The bench owns the PRF contents, and its reference
// model tracks each op by the edge at which it was issued. An op issued at edge
// e works like this:
//   - it reads the PRF as it stands after all writes at edges < e;
//   - its outputs show after edge e+1, and it writes the PRF at edge e+2;
//   - a flush or reset at edge e or e+1 kills it;
//   - with forwarding built in, it also sees the live results of ops issued at
//     edge e-1, and lane 1 wins when both lanes match.
module tb_alu_exec_wb;
    import common::*;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  issue_valid;
    alu_cmd_t    issue_alu_cmd   [2];
    logic [5:0]  issue_op1       [2];
    op_type_t    issue_op2_type  [2];
    logic [31:0] issue_op2       [2];
    logic [5:0]  issue_phys_rd   [2];
    logic [0:0]  issue_bank_addr [2];
    logic [3:0]  issue_rob_addr  [2];
    logic [5:0]  prf_raddr1      [2];
    logic [5:0]  prf_raddr2      [2];
    logic [31:0] prf_rdata1      [2];
    logic [31:0] prf_rdata2      [2];
    logic [1:0]  prf_we;
    logic [5:0]  prf_waddr       [2];
    logic [31:0] prf_wdata       [2];
    logic [1:0]  wb_valid;
    logic [5:0]  wb_phys_rd      [2];
    logic [1:0]  cmpl_valid;
    logic [3:0]  cmpl_rob_addr   [2];
    logic [0:0]  cmpl_bank_addr  [2];

    alu_exec_wb dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_alu_cmd(issue_alu_cmd),
        .issue_op1(issue_op1), .issue_op2_type(issue_op2_type),
        .issue_op2(issue_op2), .issue_phys_rd(issue_phys_rd),
        .issue_bank_addr(issue_bank_addr), .issue_rob_addr(issue_rob_addr),
        .prf_raddr1(prf_raddr1), .prf_raddr2(prf_raddr2),
        .prf_rdata1(prf_rdata1), .prf_rdata2(prf_rdata2),
        .prf_we(prf_we), .prf_waddr(prf_waddr), .prf_wdata(prf_wdata),
        .wb_valid(wb_valid), .wb_phys_rd(wb_phys_rd),
        .cmpl_valid(cmpl_valid), .cmpl_rob_addr(cmpl_rob_addr),
        .cmpl_bank_addr(cmpl_bank_addr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Bench-owned PRF plus the per-edge record of every issued op
    logic [31:0] mem [64];
    bit          rec_valid [N][2];
    logic [5:0]  rec_rd    [N][2];
    logic [31:0] rec_data  [N][2];
    logic [3:0]  rec_rob   [N][2];
    logic [0:0]  rec_bank  [N][2];
    bit          rst_at    [N];

    // Staged op for the next edge
    bit          st_valid [2];
    logic [3:0]  st_cmd   [2];
    logic [1:0]  st_type  [2];
    logic [5:0]  st_op1   [2];
    logic [31:0] st_op2   [2];
    logic [5:0]  st_rd    [2];
    logic [3:0]  st_rob   [2];
    logic [0:0]  st_bank  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] cmd, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (cmd)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return a >> sh;
            4'd4:    return 32'($signed(a) >>> sh);
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a & b;
            4'd8:    return a | b;
            4'd9:    return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_op(input int l, input bit v, input logic [3:0] cmd, input logic [1:0] typ,
                          input logic [5:0] op1, input logic [31:0] op2, input logic [5:0] rd,
                          input logic [3:0] rob, input logic [0:0] bank);
        st_valid[l] = v;   st_cmd[l] = cmd;  st_type[l] = typ; st_op1[l] = op1;
        st_op2[l]   = op2; st_rd[l]  = rd;   st_rob[l]  = rob; st_bank[l] = bank;
    endtask

    task automatic rand_op(input int l);
        set_op(l, bit'($urandom_range(0, 1)), 4'($urandom_range(0, 11)),
               2'($urandom_range(0, 3)), 6'($urandom_range(0, 15)),
               (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63))),
               6'($urandom_range(0, 15)), 4'($urandom), 1'(l));
    endtask

    task automatic idle_ops();
        set_op(0, 0, 4'd0, 2'd0, 6'd0, 32'd0, 6'd0, 4'd0, 1'd0);
        set_op(1, 0, 4'd0, 2'd0, 6'd0, 32'd0, 6'd0, 4'd0, 1'd1);
    endtask

    // Compare what the DUT shows after edge cyc with what the model predicts
    task automatic check_outputs();
        bit ev;
        if (cyc == 0) return;
        for (int l = 0; l < 2; l++) begin
            if (rst_at[cyc]) begin
                chk($sformatf("rst_prf_we%0d", l), 32'(prf_we[l]), 32'd0);
                chk($sformatf("rst_wb_valid%0d", l), 32'(wb_valid[l]), 32'd0);
                chk($sformatf("rst_cmpl_valid%0d", l), 32'(cmpl_valid[l]), 32'd0);
                chk($sformatf("rst_prf_waddr%0d", l), 32'(prf_waddr[l]), 32'd0);
                chk($sformatf("rst_prf_wdata%0d", l), prf_wdata[l], 32'd0);
                chk($sformatf("rst_wb_phys_rd%0d", l), 32'(wb_phys_rd[l]), 32'd0);
                chk($sformatf("rst_cmpl_rob%0d", l), 32'(cmpl_rob_addr[l]), 32'd0);
                chk($sformatf("rst_cmpl_bank%0d", l), 32'(cmpl_bank_addr[l]), 32'd0);
            end else begin
                ev = rec_valid[cyc-1][l];
                chk($sformatf("prf_we%0d", l), 32'(prf_we[l]), 32'(ev));
                chk($sformatf("wb_valid%0d", l), 32'(wb_valid[l]), 32'(ev));
                chk($sformatf("cmpl_valid%0d", l), 32'(cmpl_valid[l]), 32'(ev));
                if (ev) begin
                    chk($sformatf("prf_waddr%0d", l), 32'(prf_waddr[l]), 32'(rec_rd[cyc-1][l]));
                    chk($sformatf("wb_phys_rd%0d", l), 32'(wb_phys_rd[l]), 32'(rec_rd[cyc-1][l]));
                    chk($sformatf("prf_wdata%0d", l), prf_wdata[l], rec_data[cyc-1][l]);
                    chk($sformatf("cmpl_rob%0d", l), 32'(cmpl_rob_addr[l]), 32'(rec_rob[cyc-1][l]));
                    chk($sformatf("cmpl_bank%0d", l), 32'(cmpl_bank_addr[l]), 32'(rec_bank[cyc-1][l]));
                end
            end
        end
    endtask

    // One clock: called at the negedge, returns at the next negedge
    task automatic step(input bit f, input bit r);
        int          e;
        logic [31:0] a, b;
        logic [31:0] rd1 [2];
        logic [31:0] rd2 [2];
        check_outputs();
        e = cyc + 1;
        rst   = r;
        flush = f;
        for (int l = 0; l < 2; l++) begin
            issue_valid[l]     = st_valid[l];
            issue_alu_cmd[l]   = alu_cmd_t'(st_cmd[l]);
            issue_op2_type[l]  = op_type_t'(st_type[l]);
            issue_op1[l]       = st_op1[l];
            issue_op2[l]       = st_op2[l];
            issue_phys_rd[l]   = st_rd[l];
            issue_rob_addr[l]  = st_rob[l];
            issue_bank_addr[l] = st_bank[l];
        end
        rst_at[e] = r;
        if (f || r) begin
            rec_valid[e-1][0] = 0;
            rec_valid[e-1][1] = 0;
        end
        if (e >= 3) begin
            for (int l = 0; l < 2; l++)
                if (rec_valid[e-3][l]) mem[rec_rd[e-3][l]] = rec_data[e-3][l];
        end
        for (int l = 0; l < 2; l++) begin
            a = mem[st_op1[l]];
            if (st_type[l] == 2'd0)      b = mem[st_op2[l][5:0]];
            else if (st_type[l] == 2'd1) b = st_op2[l];
            else                         b = 32'd0;
`ifdef ALU_EXEC_WB_BYPASS_EN
            for (int s = 0; s < 2; s++) begin
                if (rec_valid[e-1][s] && rec_rd[e-1][s] == st_op1[l]) a = rec_data[e-1][s];
                if (st_type[l] == 2'd0 && rec_valid[e-1][s] && rec_rd[e-1][s] == st_op2[l][5:0])
                    b = rec_data[e-1][s];
            end
`endif
            rec_valid[e][l] = st_valid[l] && !f && !r;
            rec_rd[e][l]    = st_rd[l];
            rec_rob[e][l]   = st_rob[l];
            rec_bank[e][l]  = st_bank[l];
            rec_data[e][l]  = alu_ref(st_cmd[l], a, b);
        end
        #1;
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("prf_raddr1_%0d", l), 32'(prf_raddr1[l]), 32'(st_op1[l]));
            chk($sformatf("prf_raddr2_%0d", l), 32'(prf_raddr2[l]), 32'(st_op2[l][5:0]));
            rd1[l] = mem[prf_raddr1[l]];
            rd2[l] = mem[prf_raddr2[l]];
        end
        @(posedge clk);
        cyc = e;
        #1;
        for (int l = 0; l < 2; l++) begin
            prf_rdata1[l] = rd1[l];
            prf_rdata2[l] = rd2[l];
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        issue_valid = 2'b00;
        for (int l = 0; l < 2; l++) begin
            prf_rdata1[l] = 32'd0;
            prf_rdata2[l] = 32'd0;
        end
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        idle_ops();
        @(negedge clk);
        step(0, 1);
        step(0, 1);
        step(0, 0);

        // ADD with immediate: 0x10 + 0x7
        mem[5] = 32'h10;
        set_op(0, 1, ALU_ADD, OP_IMM, 6'd5, 32'h7, 6'd12, 4'd3, 1'd0);
        step(0, 0);
        idle_ops();
        repeat (3) step(0, 0);

        // Both lanes: SUB 3-5 via registers, SLTU 3 < 0xFFFFFFFF
        mem[3] = 32'd3;
        mem[4] = 32'd5;
        set_op(0, 1, ALU_SUB, OP_REG, 6'd3, 32'd4, 6'd13, 4'd4, 1'd0);
        set_op(1, 1, ALU_SLTU, OP_IMM, 6'd3, 32'hFFFF_FFFF, 6'd14, 4'd5, 1'd1);
        step(0, 0);
        idle_ops();
        repeat (3) step(0, 0);

        // SRA by 0x24 (shift 4) and SLL by 33 (shift 1)
        mem[6] = 32'h8000_0000;
        mem[7] = 32'd1;
        set_op(0, 1, ALU_SRA, OP_IMM, 6'd6, 32'h24, 6'd15, 4'd6, 1'd0);
        set_op(1, 1, ALU_SLL, OP_IMM, 6'd7, 32'd33, 6'd16, 4'd7, 1'd1);
        step(0, 0);
        idle_ops();
        repeat (3) step(0, 0);

        // Back-to-back issues on four consecutive cycles
        for (int i = 0; i < 4; i++) begin
            set_op(0, 1, 4'(i), OP_IMM, 6'(i), 32'(i + 1), 6'(20 + i), 4'(i), 1'd0);
            set_op(1, 1, ALU_XOR, OP_REG, 6'(i + 4), 32'(i + 8), 6'(30 + i), 4'(i + 8), 1'd1);
            step(0, 0);
        end
        idle_ops();
        repeat (3) step(0, 0);

        // Flush at T+1 kills op A and the op B issued with it; op C at T+2 completes
        set_op(0, 1, ALU_ADD, OP_IMM, 6'd1, 32'd1, 6'd40, 4'd1, 1'd0);
        step(0, 0);
        set_op(0, 1, ALU_OR, OP_IMM, 6'd2, 32'd2, 6'd41, 4'd2, 1'd0);
        step(1, 0);
        set_op(0, 1, ALU_AND, OP_IMM, 6'd3, 32'hF, 6'd42, 4'd3, 1'd0);
        step(0, 0);
        idle_ops();
        repeat (4) step(0, 0);

        // Same-cycle write/read of tag 9: stale 0 from the PRF, or 0x55 when forwarded
        mem[0] = 32'd0;
        mem[9] = 32'd0;
        set_op(1, 1, ALU_ADD, OP_IMM, 6'd0, 32'h55, 6'd9, 4'd9, 1'd1);
        step(0, 0);
        idle_ops();
        set_op(0, 1, ALU_ADD, OP_IMM, 6'd9, 32'd0, 6'd50, 4'd10, 1'd0);
        step(0, 0);
        idle_ops();
        repeat (3) step(0, 0);

        // Reset mid-stream
        for (int i = 0; i < 6; i++) begin
            rand_op(0);
            rand_op(1);
            step(0, i == 3);
        end

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            rand_op(0);
            rand_op(1);
            step($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
        end
        idle_ops();
        repeat (4) step(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
